// File: rtl/wr_ingress_ctrl.sv
// -----------------------------------------------------------------------------
// wr_ingress_ctrl
//   Write-side ingress stage of the async FIFO. Converts an upstream
//   valid/ready stream into FIFO write strobes through a 2-entry skid buffer,
//   so a full FIFO back-pressures upstream without dropping words. Also
//   derives the write-domain fill level and a programmable almost-full flag
//   from the local Gray write pointer and the synchronized Gray read pointer.
//
// Ports
//   i_clk, i_rst      write clock, synchronous active-high reset
//   i_s_valid/_data   upstream word and its valid
//   o_s_ready         upstream may transfer (registered)
//   o_w_en, o_wdata   write strobe and word towards the write-pointer block/RAM
//   i_wfull_flag      registered full flag from the write-pointer block
//   i_wptr            Gray write pointer (ADDRSIZE+1 bits)
//   i_rptr_sync       Gray read pointer, synchronized into i_clk
//   i_afull_thresh    almost-full threshold in words, 0 disables
//   o_wlevel          registered fill level 0..2^ADDRSIZE
//   o_afull_flag      registered almost-full
//
// Skid buffer states
//   state       | meaning
//   SKID_EMPTY  | no word buffered, o_w_en low
//   SKID_ONE    | head valid, tail free
//   SKID_TWO    | head and tail valid, upstream held off
// -----------------------------------------------------------------------------
module wr_ingress_ctrl #(
  parameter int ADDRSIZE = 4,
  parameter int DSIZE    = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_s_valid,
  input  logic [DSIZE-1:0]    i_s_data,
  output logic                o_s_ready,
  output logic                o_w_en,
  output logic [DSIZE-1:0]    o_wdata,
  input  logic                i_wfull_flag,
  input  logic [ADDRSIZE:0]   i_wptr,
  input  logic [ADDRSIZE:0]   i_rptr_sync,
  input  logic [ADDRSIZE:0]   i_afull_thresh,
  output logic [ADDRSIZE:0]   o_wlevel,
  output logic                o_afull_flag
);

  localparam int PW = ADDRSIZE + 1;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_e;

  skid_state_e       state_q, state_d;
  logic [DSIZE-1:0]  head_q, head_d;
  logic [DSIZE-1:0]  tail_q, tail_d;
  logic              ready_q, ready_d;
  logic [PW-1:0]     wlevel_q, wlevel_d;
  logic              afull_q, afull_d;

  logic              push;
  logic              pop;
  logic [PW-1:0]     wbin;
  logic [PW-1:0]     rbin;

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // pop mirrors the write-pointer block's increment condition (enable & ~full),
  // so each asserted o_w_en is exactly one RAM write.
  assign push   = i_s_valid & ready_q;
  assign o_w_en = (state_q != SKID_EMPTY) & ~i_wfull_flag;
  assign pop    = o_w_en;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      SKID_EMPTY: begin
        if (push) begin
          head_d  = i_s_data;
          state_d = SKID_ONE;
        end
      end
      SKID_ONE: begin
        case ({push, pop})
          2'b10: begin
            tail_d  = i_s_data;
            state_d = SKID_TWO;
          end
          2'b01: state_d = SKID_EMPTY;
          // head leaves to the RAM while the new word takes its place
          2'b11: head_d = i_s_data;
          default: ;
        endcase
      end
      SKID_TWO: begin
        // ready is low here, so only a pop can occur
        if (pop) begin
          head_d  = tail_q;
          state_d = SKID_ONE;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
    ready_d = (state_d != SKID_TWO);
  end

  // Level uses the lagging synchronized read pointer, so it is pessimistic;
  // words still in the skid buffer are not counted.
  assign wbin = gray2bin(i_wptr);
  assign rbin = gray2bin(i_rptr_sync);

  always_comb begin
    wlevel_d = wbin - rbin;
    afull_d  = (i_afull_thresh != '0) && (wlevel_d >= i_afull_thresh);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= SKID_EMPTY;
      head_q   <= '0;
      tail_q   <= '0;
      ready_q  <= 1'b0;
      wlevel_q <= '0;
      afull_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      ready_q  <= ready_d;
      wlevel_q <= wlevel_d;
      afull_q  <= afull_d;
    end
  end

  assign o_s_ready    = ready_q;
  assign o_wdata      = head_q;
  assign o_wlevel     = wlevel_q;
  assign o_afull_flag = afull_q;

endmodule

// File: tb/tb_wr_ingress_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wr_ingress_ctrl
//   Scoreboard bench for wr_ingress_ctrl: accepted words are queued, every
//   o_w_en pops and compares. Level/almost-full checked against constants.
// -----------------------------------------------------------------------------
module tb_wr_ingress_ctrl;

  localparam int ADDRSIZE = 4;
  localparam int DSIZE    = 8;
  localparam int PW       = ADDRSIZE + 1;

  logic             i_clk = 1'b0;
  logic             i_rst;
  logic             i_s_valid;
  logic [DSIZE-1:0] i_s_data;
  logic             o_s_ready;
  logic             o_w_en;
  logic [DSIZE-1:0] o_wdata;
  logic             i_wfull_flag;
  logic [PW-1:0]    i_wptr;
  logic [PW-1:0]    i_rptr_sync;
  logic [PW-1:0]    i_afull_thresh;
  logic [PW-1:0]    o_wlevel;
  logic             o_afull_flag;

  always #5 i_clk = ~i_clk;

  wr_ingress_ctrl #(.ADDRSIZE(ADDRSIZE), .DSIZE(DSIZE)) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_s_valid      (i_s_valid),
    .i_s_data       (i_s_data),
    .o_s_ready      (o_s_ready),
    .o_w_en         (o_w_en),
    .o_wdata        (o_wdata),
    .i_wfull_flag   (i_wfull_flag),
    .i_wptr         (i_wptr),
    .i_rptr_sync    (i_rptr_sync),
    .i_afull_thresh (i_afull_thresh),
    .o_wlevel       (o_wlevel),
    .o_afull_flag   (o_afull_flag)
  );

  int               n_tests = 0;
  int               n_fail  = 0;
  logic [DSIZE-1:0] sb_q[$];
  logic [PW-1:0]    wbin;
  logic [PW-1:0]    rbin;
  logic             track_rd;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] to_gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // One cycle: drive at negedge, observe 1 ns later, scoreboard the transfers
  // that the next rising edge will perform.
  task automatic step(input logic rst, input logic valid, input logic [DSIZE-1:0] data,
                      input logic full, output logic acc, output logic wr);
    logic [DSIZE-1:0] exp_w;
    @(negedge i_clk);
    i_rst        = rst;
    i_s_valid    = valid;
    i_s_data     = data;
    i_wfull_flag = full;
    i_wptr       = to_gray(wbin);
    i_rptr_sync  = to_gray(rbin);
    #1;
    acc = !rst && valid && o_s_ready;
    wr  = !rst && o_w_en;
    if (wr) begin
      if (sb_q.size() == 0) begin
        check_val("sb_underflow", sb_q.size(), 1);
      end else begin
        exp_w = sb_q.pop_front();
        check_val("wdata", o_wdata, exp_w);
      end
      wbin = wbin + 1'b1;
      if (track_rd) rbin = wbin;
    end
    if (acc) sb_q.push_back(data);
  endtask

  task automatic settle(input int n);
    logic a, w;
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 8'h00, 1'b0, a, w);
  endtask

  initial begin
    logic             acc, wr;
    logic [DSIZE-1:0] d;
    int               nwr, nacc, ready_low;

    i_rst = 1'b1; i_s_valid = 1'b0; i_s_data = '0; i_wfull_flag = 1'b0;
    i_wptr = '0; i_rptr_sync = '0; i_afull_thresh = '0;
    wbin = '0; rbin = '0; track_rd = 1'b1;

    // reset state
    step(1'b1, 1'b0, 8'h00, 1'b0, acc, wr);
    step(1'b1, 1'b0, 8'h00, 1'b0, acc, wr);
    check_val("rst_ready",  o_s_ready,    0);
    check_val("rst_wen",    o_w_en,       0);
    check_val("rst_wlevel", o_wlevel,     0);
    check_val("rst_afull",  o_afull_flag, 0);

    // streaming after release: ready low one cycle, then one write per cycle
    d = 8'h01; nwr = 0; ready_low = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, d, 1'b0, acc, wr);
      if (i == 0) check_val("ready_cycle1", o_s_ready, 0);
      if (i == 1) check_val("ready_cycle2", o_s_ready, 1);
      if (i >= 1 && !o_s_ready) ready_low++;
      if (acc) d++;
      if (wr) nwr++;
    end
    check_val("stream_writes", nwr, 18);
    check_val("stream_ready_low", ready_low, 0);
    settle(2);
    check_val("stream_drained", sb_q.size(), 0);

    // full back-pressure: exactly two words taken
    d = 8'hA0; nacc = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, d, 1'b1, acc, wr);
      if (acc) begin d++; nacc++; end
    end
    check_val("full_accepts", nacc, 2);
    check_val("full_ready",   o_s_ready, 0);
    check_val("full_wen",     o_w_en, 0);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, d, 1'b0, acc, wr);
      if (acc) d++;
    end
    settle(3);
    check_val("full_drained", sb_q.size(), 0);

    // level and almost-full
    track_rd = 1'b0;
    wbin = 5'd16; rbin = 5'd0; i_afull_thresh = 5'd14;
    settle(2);
    check_val("lvl_full",      o_wlevel, 16);
    check_val("afull_thr14",   o_afull_flag, 1);
    i_afull_thresh = 5'd0;  settle(2);
    check_val("afull_thr0",    o_afull_flag, 0);
    i_afull_thresh = 5'd16; settle(2);
    check_val("afull_thr16",   o_afull_flag, 1);
    i_afull_thresh = 5'd17; settle(2);
    check_val("afull_thr17",   o_afull_flag, 0);
    wbin = 5'd3; rbin = 5'd29; i_afull_thresh = 5'd7;
    settle(2);
    check_val("lvl_wrap",      o_wlevel, 6);
    check_val("afull_wrap7",   o_afull_flag, 0);
    i_afull_thresh = 5'd6;  settle(2);
    check_val("afull_wrap6",   o_afull_flag, 1);

    // reset with two words buffered and the FIFO full
    wbin = 5'd16; rbin = 5'd0; i_afull_thresh = 5'd14;
    d = 8'hB0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, d, 1'b1, acc, wr);
      if (acc) d++;
    end
    check_val("pre_rst_ready", o_s_ready, 0);
    check_val("pre_rst_afull", o_afull_flag, 1);
    step(1'b1, 1'b1, d, 1'b1, acc, wr);
    sb_q.delete();
    wbin = '0; rbin = '0; track_rd = 1'b1; i_afull_thresh = '0;
    d = 8'hC0;
    step(1'b0, 1'b1, d, 1'b0, acc, wr);
    check_val("mid_rst_ready",  o_s_ready, 0);
    check_val("mid_rst_wen",    o_w_en, 0);
    check_val("mid_rst_wlevel", o_wlevel, 0);
    check_val("mid_rst_afull",  o_afull_flag, 0);
    if (acc) d++;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, d, 1'b0, acc, wr);
      if (acc) d++;
    end
    settle(3);
    check_val("post_rst_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wr_ingress_ctrl.md
Name: wr_ingress_ctrl

Overview:
- Write-side ingress stage of the async FIFO. It sits directly upstream of the write-pointer/full-flag block and drives that block's write-enable and the RAM write data.
- Converts an upstream valid/ready stream into FIFO write strobes through a 2-entry skid buffer, so full back-pressure never drops data.
- Computes write-domain fill level and a programmable almost-full flag from the local Gray write pointer and the synchronized Gray read pointer.
- Entirely in the write clock domain.

Parameters:
- ADDRSIZE, 4, FIFO address width; depth = 2^ADDRSIZE; pointers are ADDRSIZE+1 bits.
- DSIZE, 8, data word width.

Ports:
- i_clk  input  1  write-domain clock.
- i_rst  input  1  synchronous active-high reset.
- i_s_valid  input  1  upstream word valid.
- i_s_data  input  DSIZE  upstream word.
- o_s_ready  output  1  upstream may transfer; registered.
- o_w_en  output  1  FIFO write enable to the write-pointer block.
- o_wdata  output  DSIZE  word written to RAM when o_w_en and not full.
- i_wfull_flag  input  1  registered full flag from the write-pointer block.
- i_wptr  input  ADDRSIZE+1  Gray write pointer from the write-pointer block.
- i_rptr_sync  input  ADDRSIZE+1  Gray read pointer, already synchronized into i_clk.
- i_afull_thresh  input  ADDRSIZE+1  almost-full threshold in words; 0 disables.
- o_wlevel  output  ADDRSIZE+1  registered fill level, 0..2^ADDRSIZE.
- o_afull_flag  output  1  registered almost-full.

Behaviour:
- Reset (i_rst=1 at a rising edge): skid count 0, both entries cleared, o_s_ready=0, o_wlevel=0, o_afull_flag=0. o_w_en is 0 because the count is 0.
- Reset mid-operation discards buffered words. There is no partial-write recovery.
- Upstream accept: push = i_s_valid & o_s_ready. An accepted word enters the skid buffer at the next edge.
- Downstream write: o_w_en = (cnt!=0) & ~i_wfull_flag, combinational from registered state.
  - o_wdata = head entry.
  - pop = o_w_en. This matches the write-pointer block's increment condition (enable & ~full), so every asserted o_w_en is exactly one RAM write.
- Skid buffer: 2 entries, FIFO order, cnt in {0,1,2}.
  - cnt_next = cnt + push - pop.
  - On a simultaneous push and pop at cnt=1, the head is replaced by the incoming word and cnt stays 1.
  - At cnt=2, push is impossible (ready=0).
  - At cnt=0, pop is impossible.
- o_s_ready is registered: o_s_ready <= (cnt_next < 2). It is low for exactly the first cycle after reset release.
  - While i_wfull_flag=1, at most 2 words are accepted, then ready deasserts.
  - Ready reasserts on the cycle after the first pop.
- Level:
  - Convert both Gray pointers to binary with a prefix XOR from the MSB.
  - lvl = wbin - rbin, modulo 2^(ADDRSIZE+1).
  - o_wlevel <= lvl, one cycle of latency.
  - A full FIFO reads 2^ADDRSIZE. Pointer wrap past 2^(ADDRSIZE+1) is handled by the modulo subtraction.
- Almost-full: o_afull_flag <= (i_afull_thresh != 0) & (lvl >= i_afull_thresh). Registered in the same cycle as o_wlevel.
  - Thresholds above 2^ADDRSIZE never assert.
- The level is pessimistic, because i_rptr_sync lags the reader. This is required behaviour, not an error.
- Skid-buffer words are not counted in o_wlevel.
- No X propagation: o_wdata holds the last head value when cnt=0.

Test Plan:
- Reset release, i_s_valid held 1, data 0x01,0x02,..., full=0, pointers advancing with each write:
  - o_s_ready is 0 in cycle 1 and 1 from cycle 2.
  - Words appear on o_wdata in order, one per cycle after the initial fill.
  - No gaps once steady.
- i_wfull_flag forced 1, continuous valid:
  - Exactly 2 words accepted, then o_s_ready=0.
  - Releasing full: 0xA0 then 0xA1 written first, in order, with none lost or duplicated.
- ADDRSIZE=4, i_wptr=Gray(16), i_rptr_sync=Gray(0) -> o_wlevel=16 one cycle later.
  - With i_afull_thresh=14 -> o_afull_flag=1.
  - With i_afull_thresh=0 -> o_afull_flag=0.
- Wrap: i_wptr=Gray(3), i_rptr_sync=Gray(29) -> o_wlevel=6; with threshold 7 -> o_afull_flag=0.
- Simultaneous push and pop at cnt=1 for 10 cycles: cnt stays 1, o_s_ready stays 1, output order matches input order.
- i_rst asserted with cnt=2 and full=1:
  - Next edge: o_s_ready=0, o_w_en=0, o_wlevel=0, o_afull_flag=0.
  - After release, stale words never appear on o_wdata.
